// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory subsystem: loader states,
// the default memory geometry and a constant-foldable clog2.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } load_state_e;

    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    localparam int IMEM_DEPTH = 1024;
    localparam int IMEM_IDXW  = CLOG2(IMEM_DEPTH);

endpackage

// File: rtl/imem_load_ctrl.sv
// Program-load controller: streams host words into instruction memory from a
// base byte address while holding the CPU fetch path.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = IMEM_DEPTH,
    localparam int IDXW  = CLOG2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic [XLEN-1:0] load_base,
    input  logic [IDXW:0]   load_count,
    input  logic            s_valid,
    input  logic [31:0]     s_data,
    output logic            s_ready,
    output logic            mem_we,
    output logic [IDXW-1:0] mem_widx,
    output logic [31:0]     mem_wdata,
    output logic            cpu_hold,
    output logic            load_busy,
    output logic            load_done,
    output logic            load_err
);

    load_state_e     state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW:0]   rem_q, rem_d;
    logic            we_q, we_d;
    logic [IDXW-1:0] widx_q, widx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [IDXW-1:0] base_idx;
    logic [IDXW+1:0] end_idx;
    logic            start_bad;

    // The end index is one bit wider than the count so base+count cannot wrap.
    assign base_idx  = load_base[IDXW+1:2];
    assign end_idx   = {2'b00, base_idx} + {1'b0, load_count};
    assign start_bad = (|load_base[1:0])
                     || ((load_base >> (IDXW + 2)) != '0)
                     || (end_idx > (IDXW+2)'(DEPTH));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        we_d    = 1'b0;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (load_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            idx_d   = base_idx;
                            rem_d   = load_count;
                            state_d = LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                if (s_valid) begin
                    we_d    = 1'b1;
                    widx_d  = idx_q;
                    wdata_d = s_data;
                    idx_d   = idx_q + IDXW'(1);
                    rem_d   = rem_q - (IDXW+1)'(1);
                    if (rem_q == (IDXW+1)'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign s_ready   = (state_q == LOAD);
    assign cpu_hold  = (state_q == LOAD) || (state_q == FLUSH);
    assign load_busy = cpu_hold;
    assign mem_we    = we_q;
    assign mem_widx  = widx_q;
    assign mem_wdata = wdata_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized bench for imem_load_ctrl against a beat-counting reference model.
module tb_imem_load_ctrl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int IDXW  = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load_start = 1'b0;
    logic [XLEN-1:0] load_base = '0;
    logic [IDXW:0]   load_count = '0;
    logic            s_valid = 1'b0;
    logic [31:0]     s_data = '0;
    logic            s_ready, mem_we, cpu_hold, load_busy, load_done, load_err;
    logic [IDXW-1:0] mem_widx;
    logic [31:0]     mem_wdata;

    int n_chk = 0;
    int n_fail = 0;
    bit err_model = 1'b0;
    logic [31:0] words   [DEPTH];
    logic [31:0] mem_obs [DEPTH];

    imem_load_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
        .load_count(load_count), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_widx(mem_widx), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // vmode: 0 valid always high, 1 valid every other cycle, 2 random valid.
    task automatic run_load(input logic [31:0] base, input int count, input int vmode,
                            input bit fixed_words, input bit poke_start, input int rst_after,
                            output int hold_cnt, output int done_cyc);
        int base_idx, acc, last_edge, limit, c;
        bit bad, prev_beat, loading, flush, e_done, e_hold, beat, v, do_rst;
        logic [IDXW-1:0] prev_idx;
        logic [31:0] prev_data;
        base_idx = int'(base[IDXW+1:2]);
        bad = (base[1:0] != 2'b00) || ((base >> (IDXW + 2)) != 0) || (base_idx + count > DEPTH);
        for (int i = 0; i < count; i++) begin
            words[i] = fixed_words ? 32'h11111111 * (i + 1) : $urandom;
            if (!bad) mem_obs[base_idx + i] = 'x;
        end
        load_start = 1'b1; load_base = base; load_count = (IDXW+1)'(count);
        s_valid = 1'($urandom % 2); s_data = $urandom;
        @(posedge clk); #1;
        load_start = 1'b0;
        err_model = bad;
        acc = 0; last_edge = -10; prev_beat = 1'b0; hold_cnt = 0; done_cyc = -1;
        prev_idx = '0; prev_data = '0;
        limit = (vmode == 0) ? count + 4 : 4 * count + 12;
        for (c = 1; c <= limit; c++) begin
            loading = !bad && count > 0 && acc < count;
            flush   = !bad && count > 0 && last_edge == c - 1;
            e_done  = !bad && ((count == 0 && c == 1) || (count > 0 && last_edge == c - 2));
            e_hold  = loading || flush;
            n_chk++; if (s_ready !== loading) begin n_fail++; $display("FAIL s_ready c%0d: got %b want %b", c, s_ready, loading); end
            n_chk++; if (cpu_hold !== e_hold) begin n_fail++; $display("FAIL cpu_hold c%0d: got %b want %b", c, cpu_hold, e_hold); end
            n_chk++; if (load_busy !== e_hold) begin n_fail++; $display("FAIL load_busy c%0d: got %b want %b", c, load_busy, e_hold); end
            n_chk++; if (mem_we !== prev_beat) begin n_fail++; $display("FAIL mem_we c%0d: got %b want %b", c, mem_we, prev_beat); end
            if (prev_beat) begin
                n_chk++;
                if (mem_widx !== prev_idx || mem_wdata !== prev_data) begin
                    n_fail++;
                    $display("FAIL write c%0d: got idx %0h data %h want idx %0h data %h", c, mem_widx, mem_wdata, prev_idx, prev_data);
                end
            end
            n_chk++; if (load_done !== e_done) begin n_fail++; $display("FAIL load_done c%0d: got %b want %b", c, load_done, e_done); end
            n_chk++; if (load_err !== err_model) begin n_fail++; $display("FAIL load_err c%0d: got %b want %b", c, load_err, err_model); end
            if (mem_we === 1'b1) mem_obs[mem_widx] = mem_wdata;
            if (cpu_hold === 1'b1) hold_cnt++;
            if (load_done === 1'b1) done_cyc = c;
            if (e_done) break;
            if ((bad || count == 0) && c >= 3) break;
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 1) : 1'($urandom % 2);
            do_rst = (rst_after >= 0) && (acc == rst_after) && loading;
            if (do_rst) begin rst_n = 1'b0; v = 1'b1; end
            s_valid = v;
            s_data = (acc < count) ? words[acc] : $urandom;
            if (poke_start) begin
                load_start = 1'($urandom % 2); load_base = $urandom; load_count = (IDXW+1)'($urandom);
            end
            beat = loading && v && !do_rst;
            @(posedge clk); #1;
            if (do_rst) begin
                rst_n = 1'b1; load_start = 1'b0; s_valid = 1'b0; err_model = 1'b0;
                n_chk++;
                if ({s_ready, mem_we, cpu_hold, load_busy, load_done, load_err} !== 6'b0 ||
                    mem_widx !== '0 || mem_wdata !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid: got rdy%b we%b hold%b busy%b done%b err%b idx%0h data%h want all 0",
                             s_ready, mem_we, cpu_hold, load_busy, load_done, load_err, mem_widx, mem_wdata);
                end
                @(posedge clk); #1;
                n_chk++;
                if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin
                    n_fail++; $display("FAIL post_reset: got done %b hold %b want 0 0", load_done, cpu_hold);
                end
                return;
            end
            prev_beat = beat;
            if (beat) begin
                prev_idx = IDXW'(base_idx + acc);
                prev_data = words[acc];
                acc++;
                if (acc == count) last_edge = c;
            end
        end
        n_chk++;
        if (c > limit) begin n_fail++; $display("FAIL timeout: got no completion by cycle %0d want done", limit); end
        load_start = 1'b0; s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({s_ready, mem_we, cpu_hold, load_busy, load_done, load_err} !== 6'b0 ||
            mem_widx !== '0 || mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_state: got nonzero outputs want all 0");
        end
        rst_n = 1'b1;
        err_model = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int h, d;
        run_load(32'h100, 4, 0, 1'b1, 1'b0, -1, h, d);
        n_chk++; if (h != 5) begin n_fail++; $display("FAIL basic_hold: got %0d want 5", h); end
        n_chk++; if (d != 6) begin n_fail++; $display("FAIL basic_done: got %0d want 6", d); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (mem_obs[32'h40 + i] !== 32'h11111111 * (i + 1)) begin
                n_fail++; $display("FAIL basic_mem[%0d]: got %h want %h", i, mem_obs[32'h40 + i], 32'h11111111 * (i + 1));
            end
        end
    endtask

    task automatic test_toggle();
        int h, d;
        run_load(32'h100, 4, 1, 1'b1, 1'b0, -1, h, d);
        n_chk++; if (h != 8) begin n_fail++; $display("FAIL toggle_hold: got %0d want 8", h); end
        n_chk++; if (d != 9) begin n_fail++; $display("FAIL toggle_done: got %0d want 9", d); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (mem_obs[32'h40 + i] !== 32'h11111111 * (i + 1)) begin
                n_fail++; $display("FAIL toggle_mem[%0d]: got %h want %h", i, mem_obs[32'h40 + i], 32'h11111111 * (i + 1));
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] bases [3];
        int counts [3];
        int h, d;
        bases[0] = 32'h102;  counts[0] = 4;
        bases[1] = 32'hFF0;  counts[1] = 5;
        bases[2] = 32'h1000; counts[2] = 1;
        for (int k = 0; k < 3; k++) begin
            run_load(bases[k], counts[k], 0, 1'b0, 1'b0, -1, h, d);
            n_chk++;
            if (h != 0 || d != -1) begin
                n_fail++; $display("FAIL err_start%0d: got hold %0d done %0d want 0 -1", k, h, d);
            end
        end
    endtask

    task automatic test_boundary();
        int h, d;
        run_load(32'hFF0, 4, 0, 1'b0, 1'b0, -1, h, d);
        n_chk++; if (d != 6) begin n_fail++; $display("FAIL top_done: got %0d want 6", d); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (mem_obs[1020 + i] !== words[i]) begin
                n_fail++; $display("FAIL top_mem[%0d]: got %h want %h", 1020 + i, mem_obs[1020 + i], words[i]);
            end
        end
        run_load(32'h0, DEPTH, 0, 1'b0, 1'b0, -1, h, d);
        n_chk++; if (d != DEPTH + 2) begin n_fail++; $display("FAIL full_done: got %0d want %0d", d, DEPTH + 2); end
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++;
            if (mem_obs[i] !== words[i]) begin
                n_fail++; $display("FAIL full_mem[%0d]: got %h want %h", i, mem_obs[i], words[i]);
            end
        end
    endtask

    task automatic test_zero();
        int h, d;
        run_load(32'h200, 0, 0, 1'b0, 1'b0, -1, h, d);
        n_chk++;
        if (h != 0 || d != 1) begin n_fail++; $display("FAIL zero: got hold %0d done %0d want 0 1", h, d); end
    endtask

    task automatic test_ignore_start();
        int h, d;
        run_load(32'h40, 8, 2, 1'b0, 1'b1, -1, h, d);
        n_chk++; if (d == -1) begin n_fail++; $display("FAIL ignore_done: got none want pulse"); end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (mem_obs[16 + i] !== words[i]) begin
                n_fail++; $display("FAIL ignore_mem[%0d]: got %h want %h", i, mem_obs[16 + i], words[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int h, d;
        run_load(32'h100, 4, 0, 1'b1, 1'b0, 2, h, d);
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (mem_obs[32'h40 + i] !== 32'h11111111 * (i + 1)) begin
                n_fail++; $display("FAIL rstmid_mem[%0d]: got %h want %h", i, mem_obs[32'h40 + i], 32'h11111111 * (i + 1));
            end
        end
        run_load(32'h100, 4, 0, 1'b0, 1'b0, -1, h, d);
        n_chk++; if (d != 6) begin n_fail++; $display("FAIL rstmid_reload: got done %0d want 6", d); end
    endtask

    task automatic test_back_to_back();
        int h, d, cnt, bi;
        logic [31:0] base;
        bit mis;
        for (int k = 0; k < 12; k++) begin
            cnt = $urandom_range(0, 20);
            bi = $urandom_range(0, DEPTH - cnt);
            mis = ($urandom % 4) == 0;
            base = (32'(bi) << 2) | (mis ? 32'h2 : 32'h0);
            run_load(base, cnt, 2, 1'b0, 1'b0, -1, h, d);
            if (!mis) begin
                n_chk++; if (d == -1) begin n_fail++; $display("FAIL rand%0d_done: got none want pulse", k); end
                for (int i = 0; i < cnt; i++) begin
                    n_chk++;
                    if (mem_obs[bi + i] !== words[i]) begin
                        n_fail++; $display("FAIL rand%0d_mem[%0d]: got %h want %h", k, bi + i, mem_obs[bi + i], words[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_errors();
        test_boundary();
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Program-load controller for the instruction memory. It accepts a stream of 32-bit instruction words from a host or debug link over a valid/ready handshake and writes them sequentially into instruction memory from a base byte address. While loading, it holds the CPU so fetch never sees a partially written program. It sits between the debug/host interface, the instruction memory write port and the pipeline's hold/stall input.

## Interface
Parameters:
- XLEN, 32, address width.
- DEPTH, 1024, instruction memory depth in 32-bit words (power of two).
- IDXW, clog2(DEPTH), word-index width (derived localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- load_start  in  1  request a load; sampled only in IDLE.
- load_base  in  XLEN  byte address of the first word.
- load_count  in  IDXW+1  number of words to load, 0..DEPTH.
- s_valid  in  1  host word valid.
- s_data  in  32  host instruction word.
- s_ready  out  1  controller accepts a word this cycle.
- mem_we  out  1  instruction memory write enable (registered).
- mem_widx  out  IDXW  word index of the write (registered).
- mem_wdata  out  32  write data (registered).
- cpu_hold  out  1  stall/hold the CPU fetch path.
- load_busy  out  1  high in LOAD and FLUSH.
- load_done  out  1  one-cycle pulse when a load completes.
- load_err  out  1  sticky error flag, cleared by the next accepted load_start.

## Operation
- States: IDLE, LOAD, FLUSH.
- IDLE: s_ready=0, cpu_hold=0, mem_we=0.
- load_start in IDLE is validated in the same cycle:
  - load_base[1:0]!=0 -> error.
  - load_base bits above IDXW+1 nonzero -> error.
  - load_base[IDXW+1:2] + load_count > DEPTH -> error.
  - Sum computed at IDXW+2 bits so it cannot wrap.
  - Error case: load_err<=1, stay in IDLE, no writes.
  - Valid and load_count==0: load_done pulse next cycle, load_err<=0, no hold.
  - Valid and load_count>0: load_err<=0, idx<=base index, remaining<=load_count, go to LOAD.
- LOAD: s_ready=1, cpu_hold=1.
  - Each s_valid&&s_ready beat registers mem_we=1, mem_widx=idx, mem_wdata=s_data for the following cycle.
  - Then idx increments and remaining decrements.
  - idx never wraps, because overflow is rejected at start.
  - The beat that takes remaining to 0 moves the FSM to FLUSH.
- FLUSH: s_ready=0, cpu_hold=1. The final write is on the memory port this cycle. Next state is IDLE, with load_done pulsed.
- load_start outside IDLE is ignored. s_valid in IDLE or FLUSH is not accepted.
- Reset mid-operation:
  - FSM returns to IDLE and all outputs go to 0.
  - Words already written stay in memory.
  - No load_done pulse; load_err is cleared.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_widx=0, mem_wdata=0, cpu_hold=0, load_busy=0, load_done=0, load_err=0.
- s_ready, cpu_hold and load_busy are decoded from the registered state, so they have no combinational path from inputs.
- load_start sampled at edge 0 -> cycle 1: LOAD, cpu_hold=1, s_ready=1.
- Beat accepted at edge k -> mem_we=1 during cycle k+1. Sustained throughput is one word per cycle.
- Last beat accepted at edge n:
  - Cycle n+1: FLUSH, last write visible, s_ready=0.
  - Cycle n+2: IDLE, load_done=1, cpu_hold=0.
- Minimum load of N words with s_valid held high: start to done is N+2 cycles.
- Zero-count or error start at edge 0: load_done or load_err visible in cycle 1.

## Structure
- Shared package imem_pkg:
  - State enum (IDLE, LOAD, FLUSH).
  - CLOG2 function.
  - DEPTH/IDXW defaults, shared with the instruction memory and fetch stage.
- Single module, no sub-module. The registered write port is small enough to stay inline.

## Test plan
- Load 4 words 0x11111111..0x44444444 at base 0x100, s_valid always high -> writes at idx 0x40..0x43 in consecutive cycles; cpu_hold high for 5 cycles; load_done in cycle 6.
- Same load with s_valid toggled every other cycle -> identical writes and indices; no write in idle-gap cycles; cpu_hold stays high throughout.
- Starts with load_base=0x102 or base idx 1020 with count 5 (DEPTH=1024) -> load_err=1 next cycle; no mem_we; cpu_hold stays 0.
- Boundary: base idx 1020, count 4 -> last write at idx 1023, load_done, no error. Separately, count=DEPTH at base 0 -> idx 0..1023 written.
- count=0 -> load_done pulse in cycle 1, no hold, no writes. load_start asserted during LOAD -> ignored, indices unaffected.
- rst_n low for one cycle after 2 of 4 beats -> all outputs 0 next cycle, FSM in IDLE, no load_done; a new load then runs normally.
